// File: rtl/uart_rx.sv
// Oversampling UART receiver: 2-flop rx synchroniser, mid-bit sampling FSM,
// registered byte output with one-cycle valid / frame_err strobes.
module uart_rx #(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err
);

    localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 rx_meta_q, rx_meta_d;
    logic                 rx_s_q, rx_s_d;

    // Synchroniser stages idle high so reset never looks like a start bit.
    always_comb begin
        rx_meta_d = rx;
        rx_s_d    = rx_meta_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            rx_meta_q   <= rx_meta_d;
            rx_s_q      <= rx_s_d;
        end
    end

    // Frame FSM: everything but the strobes is frozen between ticks.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;

        if (tick) begin
            unique case (state_q)
                IDLE: begin
                    if (!rx_s_q) begin
                        cnt_d   = '0;
                        state_d = START;
                    end
                end
                START: begin
                    if (cnt_q == CNT_HALF) begin
                        if (!rx_s_q) begin
                            cnt_d   = '0;
                            bit_d   = '0;
                            state_d = DATA;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                        cnt_d   = '0;
                        if (bit_q == BIT_LAST) begin
                            state_d = STOP;
                        end else begin
                            bit_d = bit_q + BIT_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        if (rx_s_q) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                            state_d = IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = WAIT_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                WAIT_IDLE: begin
                    if (rx_s_q) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: tick every 4 clk, 16 ticks per bit, 8N1 frames.
module tb_uart_rx;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;

    int n_vec;
    int n_err;

    logic tick_en;
    int   div;
    int   tick_cnt;
    int   n_valid;
    int   n_ferr;
    int   n_both;
    int   last_valid_tick;
    int   last_ferr_tick;
    logic [7:0] last_data;

    uart_rx dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Divider model: one-cycle tick every 4 clk while enabled.
    initial begin
        tick = 1'b0;
        div  = 0;
        forever begin
            @(negedge clk);
            if (tick_en) begin
                div  = (div + 1) % 4;
                tick = (div == 0);
            end else begin
                tick = 1'b0;
            end
        end
    end

    initial begin
        tick_cnt = 0;
        forever begin
            @(posedge clk);
            if (tick) tick_cnt++;
        end
    end

    initial begin
        n_valid = 0;
        n_ferr  = 0;
        n_both  = 0;
        last_valid_tick = 0;
        last_ferr_tick  = 0;
        last_data = 8'h00;
        forever begin
            @(negedge clk);
            if (valid) begin
                n_valid++;
                last_data       = data;
                last_valid_tick = tick_cnt;
            end
            if (frame_err) begin
                n_ferr++;
                last_ferr_tick = tick_cnt;
            end
            if (valid && frame_err) n_both++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            do @(posedge clk); while (!tick);
        end
    endtask

    // Hold the line with tick stopped and rx toggling; nothing may move.
    task automatic freeze();
        logic sv;
        int   v0;
        int   f0;
        tick_en = 1'b0;
        sv = rx;
        v0 = n_valid;
        f0 = n_ferr;
        repeat (200) begin
            @(negedge clk);
            rx = 1'($urandom_range(0, 1));
        end
        check("freeze_valid", 32'(n_valid - v0), 0);
        check("freeze_ferr", 32'(n_ferr - f0), 0);
        @(negedge clk);
        rx = sv;
        tick_en = 1'b1;
    endtask

    // Sends start, 8 data bits LSB first, stop; n0 is the tick index before T0.
    task automatic send_frame(input logic [7:0] b, input logic stop,
                              input int freeze_bit, output int n0);
        do @(posedge clk); while (!tick);
        n0 = tick_cnt;
        @(negedge clk);
        rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rx = b[i];
            if (i == freeze_bit) begin
                wait_ticks(4);
                freeze();
                wait_ticks(12);
            end else begin
                wait_ticks(16);
            end
        end
        @(negedge clk);
        rx = stop;
        wait_ticks(16);
    endtask

    initial begin
        int n0;
        int v0;
        int f0;
        n_vec   = 0;
        n_err   = 0;
        tick_en = 1'b1;
        rx      = 1'b1;
        rst     = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_data", 32'(data), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_ferr", 32'(frame_err), 0);
        rst = 1'b0;
        wait_ticks(4);
        check("post_rst_quiet", 32'(n_valid + n_ferr), 0);

        // Single frame with latency check
        send_frame(8'hA5, 1'b1, -1, n0);
        check("a5_count", 32'(n_valid), 1);
        check("a5_data", 32'(last_data), 32'h A5);
        check("a5_lat", 32'(last_valid_tick - n0), 153);
        check("a5_ferr", 32'(n_ferr), 0);

        // Back-to-back
        send_frame(8'h00, 1'b1, -1, n0);
        check("b2b0_data", 32'(last_data), 32'h00);
        check("b2b0_lat", 32'(last_valid_tick - n0), 153);
        send_frame(8'hFF, 1'b1, -1, n0);
        check("b2b1_data", 32'(last_data), 32'hFF);
        check("b2b1_lat", 32'(last_valid_tick - n0), 153);
        check("b2b_count", 32'(n_valid), 3);
        check("b2b_ferr", 32'(n_ferr), 0);

        // Glitch rejection
        wait_ticks(4);
        v0 = n_valid;
        f0 = n_ferr;
        do @(posedge clk); while (!tick);
        @(negedge clk);
        rx = 1'b0;
        wait_ticks(3);
        @(negedge clk);
        rx = 1'b1;
        wait_ticks(30);
        check("glitch_valid", 32'(n_valid - v0), 0);
        check("glitch_ferr", 32'(n_ferr - f0), 0);
        send_frame(8'h3C, 1'b1, -1, n0);
        check("3c_data", 32'(last_data), 32'h3C);
        check("3c_count", 32'(n_valid - v0), 1);

        // Frame error then break
        v0 = n_valid;
        send_frame(8'h55, 1'b0, -1, n0);
        check("fe_count", 32'(n_ferr - f0), 1);
        check("fe_lat", 32'(last_ferr_tick - n0), 153);
        check("fe_valid", 32'(n_valid - v0), 0);
        check("fe_data_held", 32'(data), 32'h3C);
        wait_ticks(40);
        @(negedge clk);
        rx = 1'b1;
        wait_ticks(20);
        check("break_ferr", 32'(n_ferr - f0), 1);
        check("break_valid", 32'(n_valid - v0), 0);
        send_frame(8'h81, 1'b1, -1, n0);
        check("81_data", 32'(last_data), 32'h81);
        check("81_count", 32'(n_valid - v0), 1);

        // Reset mid-frame after 4 data bits of 0xF0
        do @(posedge clk); while (!tick);
        @(negedge clk);
        rx = 1'b0;
        wait_ticks(16 + 4 * 16);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mrst_data", 32'(data), 0);
        check("mrst_valid", 32'(valid), 0);
        check("mrst_ferr", 32'(frame_err), 0);
        v0 = n_valid;
        f0 = n_ferr;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_ticks(120);
        check("mrst_quiet", 32'((n_valid - v0) + (n_ferr - f0)), 0);
        send_frame(8'h7E, 1'b1, -1, n0);
        check("7e_data", 32'(last_data), 32'h7E);
        check("7e_count", 32'(n_valid - v0), 1);

        // Tick gating mid-frame
        v0 = n_valid;
        send_frame(8'hC3, 1'b1, 3, n0);
        check("gate_data", 32'(last_data), 32'hC3);
        check("gate_count", 32'(n_valid - v0), 1);
        check("gate_lat", 32'(last_valid_tick - n0), 153);

        wait_ticks(4);
        check("never_both", 32'(n_both), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Oversampling UART receiver for the LED-driver command path. It sits directly downstream of the tick-generating clock divider, which is configured for BAUD × OVERSAMPLE and whose single-cycle enable drives `tick`. The receiver synchronises the asynchronous `rx` pin, locates each frame by mid-bit sampling, and delivers each received byte with a one-cycle `valid` strobe. A one-cycle `frame_err` strobe flags bad stop bits.

## Interface
- OVERSAMPLE, 16: `tick` pulses per bit period. Must be even and ≥ 4.
- DATA_BITS, 8: data bits per frame, 5..9. Frame is 1 start bit, LSB first, no parity, 1 stop bit.
- clk  input  1  system clock; the block's only clock.
- rst  input  1  asynchronous, active-high reset.
- tick  input  1  single-`clk`-cycle enable at BAUD × OVERSAMPLE, from the clock divider.
- rx  input  1  asynchronous serial line; idles high.
- data  output  DATA_BITS  last good byte; held until the next `valid`.
- valid  output  1  one-`clk` pulse; `data` is updated in the same cycle.
- frame_err  output  1  one-`clk` pulse when the stop bit samples low.

## Operation
- **Synchroniser:** two flops on `rx`, both resetting to 1. Only the second flop output (rx_s) is used.
- **Tick gating:** state, counters and the shifter change only in cycles where `tick`=1. `valid` and `frame_err` clear in every cycle where they are not being set.
- **Counters:**
  - sample counter: 0..OVERSAMPLE-1, width $clog2(OVERSAMPLE).
  - bit index: 0..DATA_BITS-1.
  - shift register: DATA_BITS wide. Each new bit enters at the MSB and the register shifts right, so after DATA_BITS shifts it holds the word LSB-first.
- **States:**
  - IDLE: on tick with rx_s=0, clear the sample counter and go to START.
  - START: on each tick, if cnt==OVERSAMPLE/2-1, sample rx_s (mid start bit).
    - If low: go to DATA with cnt=0 and bit=0.
    - If high: treat as a glitch and return to IDLE with no output.
    - Otherwise increment cnt.
  - DATA: on each tick, if cnt==OVERSAMPLE-1, shift rx_s in and set cnt=0.
    - If bit==DATA_BITS-1, go to STOP; otherwise increment bit.
    - Otherwise increment cnt.
  - STOP: on tick with cnt==OVERSAMPLE-1, sample rx_s.
    - If high: load `data` from the shifter, pulse `valid`, go to IDLE.
    - If low: pulse `frame_err`, leave `data` unchanged, go to WAIT_IDLE.
    - Otherwise increment cnt.
  - WAIT_IDLE: on tick with rx_s=1, go to IDLE. A held-low line (break) therefore never re-triggers START.
- **Reset:** asynchronous, legal at any time, including mid-frame. Reset values:
  - state = IDLE
  - counters = 0
  - shifter = 0
  - data = 0
  - valid = 0
  - frame_err = 0
  - both synchroniser flops = 1

  After reset release, no output pulses until a complete new frame is received.

## Timing
- The rx pin reaches rx_s 2 `clk` cycles after it changes.
- T0 is the tick on which IDLE sees rx_s=0. Sample points are at T0+OVERSAMPLE/2, then every OVERSAMPLE ticks after that.
- With defaults:
  - data bit k is sampled at T0+8+16(k+1);
  - the stop bit is sampled at T0+152.
- `valid` or `frame_err` is asserted on the `clk` edge of the stop-sample tick, for exactly one cycle.
- Back-to-back frames are supported: a start edge is accepted on the first tick after STOP→IDLE, so no extra idle time is required after the stop mid-point.
- `valid` and `frame_err` are never asserted in the same cycle.

## Test plan
- **Single frame:** tick every 4 clk, rx sends 0xA5 at 16 ticks/bit → exactly one `valid`, `data`=0xA5, `frame_err` stays 0, `valid` 152 ticks after T0.
- **Back-to-back:** 0x00 immediately followed by 0xFF, each with a single stop bit → two `valid` pulses with `data` 0x00 then 0xFF, no `frame_err`.
- **Glitch rejection:** rx low for 3 ticks, then high → no `valid`, no `frame_err`, state returns to IDLE; a following 0x3C is received correctly.
- **Frame error and break recovery:**
  - 0x55 sent with stop bit low → one `frame_err` pulse, no `valid`, `data` keeps its previous value.
  - rx then held low 40 ticks and released → no further pulses.
  - next 0x81 → `valid` with `data`=0x81.
- **Reset mid-frame:** assert `rst` after 4 data bits of 0xF0 → `data`=0, `valid`=0, `frame_err`=0 immediately, no pulse for the aborted frame; 0x7E sent after release is received correctly.
- **Tick gating:** hold `tick`=0 while toggling rx for 200 clk → no state change and no output pulses; resuming ticks mid-frame continues sampling from the frozen counters.
